aes_key_expansion_writer: RTL



---
 rtl/aes_key_expansion_writer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/aes_key_expansion_writer.sv
// aes_key_expansion_writer: iterative AES-128/192/256 key schedule that writes round keys into the round-key RAM
module aes_key_expansion_writer (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iStart,
    input  logic        iEndec,
    input  logic [1:0]  iKey_size,
    input  logic [31:0] iKey_1,
    input  logic [31:0] iKey_2,
    input  logic [31:0] iKey_3,
    input  logic [31:0] iKey_4,
    input  logic [31:0] iKey_5,
    input  logic [31:0] iKey_6,
    input  logic [31:0] iKey_7,
    input  logic [31:0] iKey_8,
    output logic        oRAM_we,
    output logic [3:0]  oRAM_addr,
    output logic [31:0] oRAM_data_1,
    output logic [31:0] oRAM_data_2,
    output logic [31:0] oRAM_data_3,
    output logic [31:0] oRAM_data_4,
    output logic        oBusy,
    output logic        oDone
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t           r_state;
    logic [7:0][31:0] r_hist;
    logic [3:0][31:0] r_buf;
    logic [1:0]       r_ks;
    logic             r_endec;
    logic [5:0]       r_cnt;
    logic [2:0]       r_mod;
    logic [7:0]       r_rcon;

    logic [1:0]       w_ks;
    logic [7:0][31:0] w_key;
    logic [7:0][31:0] w_load;
    logic [3:0]       w_nr;
    logic [2:0]       w_mod_max;
    logic [31:0]      w_old;
    logic [31:0]      w_prev;
    logic [31:0]      w_rot;
    logic [31:0]      w_sub;
    logic [31:0]      w_temp;
    logic [31:0]      w_word;
    logic             w_init;
    logic             w_last;
    logic [7:0]       w_rcon_next;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    // Schedule word generation: history register holds w[i-8..i-1], newest at index 7, so w[i-Nk] sits at 8-Nk
    always_comb begin
        w_ks        = (iKey_size == 2'd3) ? 2'd0 : iKey_size;
        w_key       = {iKey_8, iKey_7, iKey_6, iKey_5, iKey_4, iKey_3, iKey_2, iKey_1};
        w_load      = (w_ks == 2'd2) ? w_key : (w_ks == 2'd1) ? (w_key << 64) : (w_key << 128);
        w_nr        = (r_ks == 2'd2) ? 4'd14 : (r_ks == 2'd1) ? 4'd12 : 4'd10;
        w_mod_max   = (r_ks == 2'd2) ? 3'd7 : (r_ks == 2'd1) ? 3'd5 : 3'd3;
        w_old       = (r_ks == 2'd2) ? r_hist[0] : (r_ks == 2'd1) ? r_hist[2] : r_hist[4];
        w_prev      = r_hist[7];
        w_init      = r_cnt <= {3'b000, w_mod_max};
        w_rot       = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        w_sub       = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
        w_temp      = (r_mod == 3'd0) ? (w_sub ^ {r_rcon, 24'h0}) :
                      (r_ks == 2'd2 && r_mod == 3'd4) ? w_sub : w_prev;
        w_word      = w_init ? w_old : (w_old ^ w_temp);
        w_last      = r_cnt == {w_nr, 2'b11};
        w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    end

    // Control FSM with registered RAM write port, busy and done outputs
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state     <= IDLE;
            r_ks        <= 2'd0;
            r_endec     <= 1'b0;
            r_cnt       <= 6'd0;
            r_mod       <= 3'd0;
            r_rcon      <= 8'h01;
            oRAM_we     <= 1'b0;
            oRAM_addr   <= 4'd0;
            oRAM_data_1 <= 32'h0;
            oRAM_data_2 <= 32'h0;
            oRAM_data_3 <= 32'h0;
            oRAM_data_4 <= 32'h0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    oDone   <= 1'b0;
                    oRAM_we <= 1'b0;
                    if (iStart) begin
                        r_ks    <= w_ks;
                        r_endec <= iEndec;
                        r_hist  <= w_load;
                        r_cnt   <= 6'd0;
                        r_mod   <= 3'd0;
                        r_rcon  <= 8'h01;
                        r_state <= EXPAND;
                    end
                end
                EXPAND: begin
                    oBusy             <= 1'b1;
                    r_hist            <= {w_word, r_hist[7:1]};
                    r_buf[r_cnt[1:0]] <= w_word;
                    r_cnt             <= r_cnt + 6'd1;
                    r_mod             <= (r_mod == w_mod_max) ? 3'd0 : r_mod + 3'd1;
                    if (!w_init && r_mod == 3'd0)
                        r_rcon <= w_rcon_next;
                    oRAM_we <= r_cnt[1:0] == 2'd3;
                    if (r_cnt[1:0] == 2'd3) begin
                        oRAM_data_1 <= r_buf[0];
                        oRAM_data_2 <= r_buf[1];
                        oRAM_data_3 <= r_buf[2];
                        oRAM_data_4 <= w_word;
                        oRAM_addr   <= r_endec ? (w_nr - r_cnt[5:2]) : r_cnt[5:2];
                    end
                    if (w_last)
                        r_state <= DONE;
                end
                DONE: begin
                    oRAM_we <= 1'b0;
                    oBusy   <= 1'b0;
                    oDone   <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
